// File: rtl/eeg_pea_eng_pe_mc.sv
// Multi-output-channel EEG PE: shared activation stream, per-channel sparse-weight
// dilated 1-D conv into a sliding psum window, requantised to one vector per position.
module eeg_pea_eng_pe_mc_lane #(
  parameter int DATA_ACT_DW = 8,
  parameter int DATA_WEI_DW = 8,
  parameter int DATA_OUT_DW = 8,
  parameter int DATA_SUM_DW = 24,
  parameter int DATA_SUM_NW = 8,
  parameter int IW          = 3,
  parameter int CONV_MUL_DW = 24,
  parameter int CONV_SFT_DW = 8,
  parameter int CONV_ADD_DW = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic                   acc_en,
  input  logic [IW-1:0]          acc_idx,
  input  logic [DATA_ACT_DW-1:0] act,
  input  logic [DATA_WEI_DW-1:0] wei,
  input  logic [CONV_MUL_DW-1:0] mul,
  input  logic [CONV_SFT_DW-1:0] sft,
  input  logic [CONV_ADD_DW-1:0] bias,
  input  logic                   relu,
  output logic [DATA_OUT_DW-1:0] q
);
  localparam int CAL = DATA_SUM_DW + CONV_MUL_DW + 1;
  localparam logic signed [CAL-1:0] OMAX = CAL'((1 << (DATA_OUT_DW - 1)) - 1);
  localparam logic signed [CAL-1:0] OMIN = ~OMAX;

  logic [DATA_SUM_NW-1:0][DATA_SUM_DW-1:0] psum;
  logic signed [DATA_SUM_DW-1:0] act_x, wei_x, prod;
  logic signed [CAL-1:0] m, r;
  logic rnd;

  assign act_x = DATA_SUM_DW'($signed(act));
  assign wei_x = DATA_SUM_DW'($signed(wei));
  assign prod  = act_x * wei_x;

  // Slot 0 is the oldest position; a shift retires it and opens an empty top slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        psum <= '0;
    else if (clr)      psum <= '0;
    else if (shift_en) psum <= {{DATA_SUM_DW{1'b0}}, psum[DATA_SUM_NW-1:1]};
    else if (acc_en)   psum[acc_idx] <= psum[acc_idx] + prod;
  end

  always_comb begin
    m = CAL'($signed(psum[0])) * CAL'({1'b0, mul}) + CAL'($signed(bias));
    if (sft == '0)            rnd = 1'b0;
    else if (32'(sft) > CAL)  rnd = m[CAL-1];
    else                      rnd = |(m & (CAL'(1) << (sft - 1'b1)));
    // keep the add signed so >>> stays arithmetic
    r = (m >>> sft) + $signed({{(CAL-1){1'b0}}, rnd});
    if (r > OMAX)      q = OMAX[DATA_OUT_DW-1:0];
    else if (r < OMIN) q = OMIN[DATA_OUT_DW-1:0];
    else               q = r[DATA_OUT_DW-1:0];
    if (relu && r < 0) q = '0;
  end
endmodule

module eeg_pea_eng_pe_mc #(
  parameter int NUM_OCH     = 4,
  parameter int DATA_ACT_DW = 8,
  parameter int DATA_WEI_DW = 8,
  parameter int DATA_OUT_DW = 8,
  parameter int DATA_SUM_DW = 24,
  parameter int DATA_SUM_NW = 8,
  parameter int ARAM_ADD_AW = 10,
  parameter int CONV_WEI_DW = 3,
  parameter int CONV_MUL_DW = 24,
  parameter int CONV_SFT_DW = 8,
  parameter int CONV_ADD_DW = 24
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             IS_IDLE,
  input  logic [CONV_WEI_DW-1:0]           CFG_CONV_DIL,
  input  logic [CONV_WEI_DW-1:0]           CFG_CONV_PAD,
  input  logic [CONV_MUL_DW-1:0]           CFG_CONV_MUL,
  input  logic [CONV_SFT_DW-1:0]           CFG_CONV_SFT,
  input  logic [NUM_OCH*CONV_ADD_DW-1:0]   CFG_CONV_ADD,
  input  logic                             CFG_RELU_EN,
  input  logic [ARAM_ADD_AW-1:0]           CFG_CONV_LST,
  input  logic                             DIN_VLD,
  output logic                             DIN_RDY,
  input  logic                             ACT_LST,
  input  logic                             WEI_LST,
  input  logic [DATA_ACT_DW-1:0]           ACT_DAT,
  input  logic [ARAM_ADD_AW-1:0]           ACT_ADD,
  input  logic [NUM_OCH*DATA_WEI_DW-1:0]   WEI_DAT,
  input  logic [CONV_WEI_DW-1:0]           WEI_IDX,
  output logic                             OUT_VLD,
  output logic                             OUT_LST,
  output logic [ARAM_ADD_AW-1:0]           OUT_ADD,
  input  logic                             OUT_RDY,
  output logic [NUM_OCH*DATA_OUT_DW-1:0]   OUT_DAT
);
  localparam int IW = (DATA_SUM_NW > 1) ? $clog2(DATA_SUM_NW) : 1;
  localparam int IX = 2 * CONV_WEI_DW + 1;
  localparam int PW = ARAM_ADD_AW + IX + 1;

  typedef enum logic [1:0] {IDLE, FLOW, DRAIN, LAST} state_t;
  state_t state, state_nxt;

  logic [ARAM_ADD_AW-1:0] c;
  logic [IX-1:0] pd, idx;
  logic signed [PW-1:0] pos0, lst_s;
  logic run, slot_free, accept, retire, step, emit, clr, acc_en;
  logic [NUM_OCH-1:0][DATA_OUT_DW-1:0] q_all;

  assign pd    = IX'(CFG_CONV_PAD) * IX'(CFG_CONV_DIL);
  assign idx   = ((IX'(CFG_CONV_PAD) << 1) - IX'(WEI_IDX)) * IX'(CFG_CONV_DIL);
  assign pos0  = $signed(PW'(c)) - $signed(PW'(pd));
  assign lst_s = $signed(PW'(CFG_CONV_LST));
  assign IS_IDLE = (state == IDLE);

  always_comb begin
    state_nxt = state;
    run       = (state == IDLE) || (state == FLOW);
    slot_free = !OUT_VLD || OUT_RDY;
    DIN_RDY   = run && (ACT_ADD == c);
    accept    = DIN_RDY && DIN_VLD;
    retire    = run && DIN_VLD && (ACT_ADD > c) && slot_free;
    step      = retire || ((state == DRAIN) && slot_free);
    emit      = step && !pos0[PW-1] && (pos0 <= lst_s);
    clr       = (state == LAST) && slot_free;
    acc_en    = accept && (idx < IX'(DATA_SUM_NW));
    case (state)
      IDLE:  if (accept && ACT_LST && WEI_LST) state_nxt = DRAIN;
             else if (accept || retire)        state_nxt = FLOW;
      FLOW:  if (accept && ACT_LST && WEI_LST) state_nxt = DRAIN;
      DRAIN: if (step && (pos0 >= lst_s))      state_nxt = LAST;
      LAST:  if (clr)                          state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      c     <= '0;
    end else begin
      state <= state_nxt;
      if (clr)       c <= '0;
      else if (step) c <= c + ARAM_ADD_AW'(1);
    end
  end

  // Output slot only reloads when free, so a stalled vector stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OUT_VLD <= 1'b0;
      OUT_LST <= 1'b0;
      OUT_ADD <= '0;
      OUT_DAT <= '0;
    end else if (slot_free) begin
      OUT_VLD <= emit;
      if (emit) begin
        OUT_ADD <= pos0[ARAM_ADD_AW-1:0];
        OUT_LST <= (pos0 == lst_s);
        OUT_DAT <= q_all;
      end
    end
  end

  for (genvar i = 0; i < NUM_OCH; i++) begin : g_lane
    eeg_pea_eng_pe_mc_lane #(
      .DATA_ACT_DW(DATA_ACT_DW), .DATA_WEI_DW(DATA_WEI_DW), .DATA_OUT_DW(DATA_OUT_DW),
      .DATA_SUM_DW(DATA_SUM_DW), .DATA_SUM_NW(DATA_SUM_NW), .IW(IW),
      .CONV_MUL_DW(CONV_MUL_DW), .CONV_SFT_DW(CONV_SFT_DW), .CONV_ADD_DW(CONV_ADD_DW)
    ) u_lane (
      .clk(clk), .rst_n(rst_n), .clr(clr), .shift_en(step), .acc_en(acc_en),
      .acc_idx(idx[IW-1:0]), .act(ACT_DAT),
      .wei(WEI_DAT[i*DATA_WEI_DW +: DATA_WEI_DW]),
      .mul(CFG_CONV_MUL), .sft(CFG_CONV_SFT),
      .bias(CFG_CONV_ADD[i*CONV_ADD_DW +: CONV_ADD_DW]),
      .relu(CFG_RELU_EN), .q(q_all[i])
    );
  end
endmodule

// File: tb/tb_eeg_pea_eng_pe_mc.sv
// Directed bench for eeg_pea_eng_pe_mc with two output channels.
module tb_eeg_pea_eng_pe_mc;
  logic        clk = 0, rst_n = 0;
  logic        IS_IDLE;
  logic [2:0]  CFG_CONV_DIL = 1, CFG_CONV_PAD = 1;
  logic [23:0] CFG_CONV_MUL = 1;
  logic [7:0]  CFG_CONV_SFT = 0;
  logic [47:0] CFG_CONV_ADD = '0;
  logic        CFG_RELU_EN = 0;
  logic [9:0]  CFG_CONV_LST = 3;
  logic        DIN_VLD = 0, DIN_RDY, ACT_LST = 0, WEI_LST = 0;
  logic [7:0]  ACT_DAT = 0;
  logic [9:0]  ACT_ADD = 5;
  logic [15:0] WEI_DAT = 0;
  logic [2:0]  WEI_IDX = 0;
  logic        OUT_VLD, OUT_LST, OUT_RDY = 1;
  logic [9:0]  OUT_ADD;
  logic [15:0] OUT_DAT;

  int checks = 0, errors = 0;
  logic [26:0] obs_q[$];

  eeg_pea_eng_pe_mc #(.NUM_OCH(2)) dut (
    .clk(clk), .rst_n(rst_n), .IS_IDLE(IS_IDLE),
    .CFG_CONV_DIL(CFG_CONV_DIL), .CFG_CONV_PAD(CFG_CONV_PAD), .CFG_CONV_MUL(CFG_CONV_MUL),
    .CFG_CONV_SFT(CFG_CONV_SFT), .CFG_CONV_ADD(CFG_CONV_ADD), .CFG_RELU_EN(CFG_RELU_EN),
    .CFG_CONV_LST(CFG_CONV_LST), .DIN_VLD(DIN_VLD), .DIN_RDY(DIN_RDY), .ACT_LST(ACT_LST),
    .WEI_LST(WEI_LST), .ACT_DAT(ACT_DAT), .ACT_ADD(ACT_ADD), .WEI_DAT(WEI_DAT),
    .WEI_IDX(WEI_IDX), .OUT_VLD(OUT_VLD), .OUT_LST(OUT_LST), .OUT_ADD(OUT_ADD),
    .OUT_RDY(OUT_RDY), .OUT_DAT(OUT_DAT)
  );

  always #5 clk = ~clk;

  // Handshake completes on the following posedge; values are stable at negedge.
  always @(negedge clk)
    if (rst_n && OUT_VLD && OUT_RDY) obs_q.push_back({OUT_LST, OUT_ADD, OUT_DAT});

  function automatic logic [26:0] w(input logic l, input logic [9:0] a,
                                    input logic [7:0] c1, input logic [7:0] c0);
    return {l, a, c1, c0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int i, input logic [26:0] e);
    logic [26:0] o;
    o = (i < obs_q.size()) ? obs_q[i] : 27'h7ffffff;
    chk($sformatf("%s[%0d]", tag, i), 64'(o), 64'(e));
  endtask

  task automatic send(input logic [9:0] a, input logic [7:0] act, input logic [7:0] w0,
                      input logic [7:0] w1, input logic [2:0] k, input logic lst);
    logic rdy;
    logic done;
    done = 0;
    DIN_VLD = 1; ACT_ADD = a; ACT_DAT = act; WEI_DAT = {w1, w0};
    WEI_IDX = k; ACT_LST = lst; WEI_LST = lst;
    for (int i = 0; i < 40 && !done; i++) begin
      #2 rdy = DIN_RDY;
      @(posedge clk); #1;
      done = rdy;
    end
    DIN_VLD = 0; ACT_LST = 0; WEI_LST = 0;
    chk("send_accept", 64'(done), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (IS_IDLE && !OUT_VLD) break;
    end
    chk(tag, 64'(IS_IDLE), 64'd1);
  endtask

  task automatic basic_cfg();
    CFG_CONV_PAD = 1; CFG_CONV_DIL = 1; CFG_CONV_LST = 3; CFG_CONV_MUL = 1;
    CFG_CONV_SFT = 0; CFG_CONV_ADD = '0; CFG_RELU_EN = 0;
  endtask

  task automatic run_basic();
    send(10'd1, 8'd3, 8'd1, 8'd2, 3'd0, 1'b0);
    send(10'd1, 8'd3, 8'd1, 8'd2, 3'd1, 1'b0);
    send(10'd1, 8'd3, 8'd1, 8'd2, 3'd2, 1'b1);
  endtask

  task automatic chk_basic(input string tag);
    chk({tag, "_cnt"}, 64'(obs_q.size()), 64'd4);
    chk_out(tag, 0, w(1'b0, 10'd0, 8'd6, 8'd3));
    chk_out(tag, 1, w(1'b0, 10'd1, 8'd6, 8'd3));
    chk_out(tag, 2, w(1'b0, 10'd2, 8'd6, 8'd3));
    chk_out(tag, 3, w(1'b1, 10'd3, 8'd0, 8'd0));
  endtask

  byte e0[8] = '{13, 10, 12, 10, 17, 10, 14, 10};
  byte e1[8] = '{-4, -3, -4, -3, -6, -3, -5, -3};

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("rst_idle", 64'(IS_IDLE), 64'd1);
    chk("rst_vld", 64'(OUT_VLD), 64'd0);
    chk("rst_lst", 64'(OUT_LST), 64'd0);
    chk("rst_add", 64'(OUT_ADD), 64'd0);
    chk("rst_dat", 64'(OUT_DAT), 64'd0);
    chk("rst_rdy_far", 64'(DIN_RDY), 64'd0);
    ACT_ADD = 0; #1;
    chk("rst_rdy_c0", 64'(DIN_RDY), 64'd1);
    @(posedge clk); #1;

    // basic conv
    basic_cfg();
    obs_q.delete();
    run_basic();
    wait_idle("basic_idle");
    chk_basic("basic");

    // requant / rounding, single-tap kernel
    CFG_CONV_PAD = 0; CFG_CONV_LST = 0; CFG_CONV_MUL = 3; CFG_CONV_SFT = 2;
    CFG_CONV_ADD = {24'hffffff, 24'h000001};
    obs_q.delete();
    send(10'd0, 8'd5, 8'd1, 8'd1, 3'd0, 1'b1);
    wait_idle("rq_idle");
    chk("rq_cnt", 64'(obs_q.size()), 64'd1);
    chk_out("rq", 0, w(1'b1, 10'd0, 8'd4, 8'd4));

    // clip, then ReLU
    CFG_CONV_MUL = 1; CFG_CONV_SFT = 0; CFG_CONV_ADD = '0;
    obs_q.delete();
    send(10'd0, 8'd100, 8'd10, 8'hf6, 3'd0, 1'b1);
    wait_idle("clip_idle");
    chk_out("clip", 0, w(1'b1, 10'd0, 8'h80, 8'h7f));
    CFG_RELU_EN = 1;
    obs_q.delete();
    send(10'd0, 8'd100, 8'd10, 8'hf6, 3'd0, 1'b1);
    wait_idle("relu_idle");
    chk_out("relu", 0, w(1'b1, 10'd0, 8'h00, 8'h7f));

    // dilation 2 with a gap between activations
    CFG_RELU_EN = 0; CFG_CONV_PAD = 1; CFG_CONV_DIL = 2; CFG_CONV_LST = 7;
    CFG_CONV_ADD = {24'hfffffd, 24'd10};
    obs_q.delete();
    send(10'd2, 8'd1, 8'd1, 8'hff, 3'd0, 1'b0);
    send(10'd2, 8'd1, 8'd2, 8'hff, 3'd1, 1'b0);
    send(10'd2, 8'd1, 8'd3, 8'hff, 3'd2, 1'b0);
    send(10'd6, 8'd2, 8'd1, 8'hff, 3'd0, 1'b0);
    send(10'd6, 8'd2, 8'd2, 8'hff, 3'd1, 1'b0);
    send(10'd6, 8'd2, 8'd3, 8'hff, 3'd2, 1'b1);
    wait_idle("dil_idle");
    chk("dil_cnt", 64'(obs_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk_out("dil", i, w(i == 7, 10'(i), 8'(e1[i]), 8'(e0[i])));

    // backpressure during drain
    basic_cfg();
    obs_q.delete();
    OUT_RDY = 0;
    run_basic();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 64'(OUT_VLD), 64'd1);
      chk("bp_add", 64'(OUT_ADD), 64'd0);
      chk("bp_dat", 64'(OUT_DAT), 64'h0603);
      chk("bp_rdy", 64'(DIN_RDY), 64'd0);
      @(posedge clk); #1;
    end
    OUT_RDY = 1;
    wait_idle("bp_idle");
    chk_basic("bp");

    // reset in the middle of FLOW, then rerun
    obs_q.delete();
    send(10'd1, 8'd3, 8'd1, 8'd2, 3'd0, 1'b0);
    send(10'd1, 8'd3, 8'd1, 8'd2, 3'd1, 1'b0);
    chk("mid_flow", 64'(IS_IDLE), 64'd0);
    rst_n = 0;
    #1;
    chk("mid_rst_idle", 64'(IS_IDLE), 64'd1);
    chk("mid_rst_vld", 64'(OUT_VLD), 64'd0);
    @(posedge clk); #1 rst_n = 1;
    obs_q.delete();
    run_basic();
    wait_idle("rerun_idle");
    chk_basic("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eeg_pea_eng_pe_mc.md
Name: eeg_pea_eng_pe_mc

Overview:
- Multi-output-channel successor of the EEG PE array engine PE: one activation stream is shared by NUM_OCH output channels, each with its own weight.
- Computes a 1-D dilated, zero-padded convolution with sparse weights into a per-channel sliding psum window.
- Requantises each output position (mul, shift, round, per-channel bias, clip, optional ReLU) and emits one NUM_OCH-wide vector per output position toward the ORAM mux.
- Sits between the PEA activation/weight fetch and the ORAM write path.

Parameters:
- NUM_OCH, 4, output channels processed in parallel.
- DATA_ACT_DW, 8, signed activation width.
- DATA_WEI_DW, 8, signed weight width per channel.
- DATA_OUT_DW, 8, signed output width per channel.
- DATA_SUM_DW, 24, signed psum width; wraps modulo 2^DATA_SUM_DW.
- DATA_SUM_NW, 8, psum window depth; must be >= 2*pad*dil+1.
- ARAM_ADD_AW, 10, activation/output address width.
- CONV_WEI_DW, 3, tap index / pad / dilation width.
- CONV_MUL_DW, 24, unsigned requant multiplier width.
- CONV_SFT_DW, 8, shift width.
- CONV_ADD_DW, 24, signed per-channel bias width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- IS_IDLE  out  1  state==IDLE.
- CFG_CONV_DIL  in  CONV_WEI_DW  dilation D, >=1.
- CFG_CONV_PAD  in  CONV_WEI_DW  pad P = kernel_len/2.
- CFG_CONV_MUL  in  CONV_MUL_DW  shared multiplier.
- CFG_CONV_SFT  in  CONV_SFT_DW  shared arithmetic right shift.
- CFG_CONV_ADD  in  NUM_OCH*CONV_ADD_DW  per-channel bias; ch i in bits [i*CONV_ADD_DW +: CONV_ADD_DW].
- CFG_RELU_EN  in  1  clamp negative outputs to 0.
- CFG_CONV_LST  in  ARAM_ADD_AW  last output position L.
- DIN_VLD  in  1  beat valid.
- DIN_RDY  out  1  beat accepted when DIN_VLD&DIN_RDY.
- ACT_LST  in  1  last activation.
- WEI_LST  in  1  last tap of current activation.
- ACT_DAT  in  DATA_ACT_DW  activation.
- ACT_ADD  in  ARAM_ADD_AW  activation address a.
- WEI_DAT  in  NUM_OCH*DATA_WEI_DW  per-channel weights.
- WEI_IDX  in  CONV_WEI_DW  tap index k, 0..2P.
- OUT_VLD  out  1  output valid.
- OUT_LST  out  1  OUT_ADD==L.
- OUT_ADD  out  ARAM_ADD_AW  output position.
- OUT_RDY  in  1  downstream ready.
- OUT_DAT  out  NUM_OCH*DATA_OUT_DW  packed requantised outputs.

Behaviour:
- Reset: state IDLE; IS_IDLE=1; OUT_VLD=0, OUT_LST=0, OUT_ADD=0, OUT_DAT=0; psum=0; centre c=0.
- Window: psum[ch][j], j=0..DATA_SUM_NW-1, holds output position pos0+j, where pos0=c-P*D (signed, may be negative).
- Input stream is ascending in ACT_ADD. Tap k of activation a contributes to position a-(k-P)*D.
- Accept: state IDLE/FLOW and ACT_ADD==c. Combinationally DIN_RDY=1; psum[ch][(2P-k)*D] += act*wei[ch], registered next cycle. Only zero weights may be skipped upstream.
- Retire: state IDLE/FLOW, DIN_VLD, ACT_ADD>c, and the output slot is free (~OUT_VLD|OUT_RDY). DIN_RDY=0. The window shifts down one (top slot <= 0) and c++.
  - If 0<=pos0<=L: pos0 is emitted; OUT_VLD=1 and OUT_ADD=pos0 the next cycle.
  - Otherwise the shift is silent.
  - The beat is held and re-evaluated next cycle.
- Accept and retire are mutually exclusive by construction.
- ACT_ADD<c with DIN_VLD is illegal; behaviour is unspecified.
- FSM: IDLE→FLOW on the first retire or accept. FLOW→DRAIN on accepting a beat with ACT_LST&WEI_LST.
- DRAIN: DIN_RDY=0. Each cycle with a free output slot, do a retire step (emit rule as above). When a step has pos0>=L, go to LAST.
- LAST: when the output is empty or OUT_RDY, clear psum and c, then go IDLE.
- Requant per channel, in CONV_CAL_DW=DATA_SUM_DW+CONV_MUL_DW+1 bits:
  - m = psum*{0,MUL} + bias.
  - r = (m>>>SFT) + (SFT?m[SFT-1]:0), i.e. round half up.
  - Clip to [-2^(DATA_OUT_DW-1), 2^(DATA_OUT_DW-1)-1].
  - If CFG_RELU_EN and result<0, output 0.
- Output register holds OUT_DAT/OUT_ADD/OUT_LST stable while OUT_VLD&~OUT_RDY. A new emission is loaded only in the cycle the slot is free. Zero bubbles when OUT_RDY=1.
- Emission latency: 1 cycle from the retire/drain step.
- CFG_* must be static outside IDLE.
- Reset mid-operation: all state and outputs return to reset values immediately; no partial output is emitted.

Test Plan:
- Basic conv: NUM_OCH=2, P=1, D=1, L=3, MUL=1, SFT=0, bias 0. Act a=1, value 3; taps 0,1,2 with weights ch0=1, ch1=2; WEI_LST/ACT_LST on tap 2 → one silent retire, 3 accepts, then outputs (ADD,ch0,ch1) = (0,3,6), (1,3,6), (2,3,6), (3,0,0) with OUT_LST on ADD=3, then IS_IDLE=1.
- Requant/round: psum ch0=5, ch1=5; MUL=3, SFT=2, bias ch0=+1, ch1=-1 → ch0: 16>>>2=4, round 0 → 4; ch1: 14>>>2=3, round 1 → 4.
- Clip/ReLU: psum ±1000, MUL=1, SFT=0 → 127 and -128. With CFG_RELU_EN=1 → 127 and 0.
- Dilation/gap: D=2, P=1, activations at a=2 and a=6 → retires across the gap emit bias-only values for intervening positions. Each tap lands at position a-(k-1)*2.
- Backpressure: OUT_RDY low for 5 cycles during DRAIN → OUT_VLD/OUT_DAT/OUT_ADD held stable, no position lost or duplicated, DIN_RDY=0.
- Reset mid-FLOW: assert rst_n low after 2 accepts → OUT_VLD=0 and IS_IDLE=1 immediately; a rerun of the basic conv matches expected values.
